// File: rtl/seg7_capture.sv
// seg7_capture: samples a 7-segment pattern, debounces it over STABLE_CYCLES samples and decodes it to BCD.
// Step classification (up/down/skip, direction) is built only when SEG7_CAPTURE_DIRCHECK_EN is defined.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_step_up,
  output logic       o_step_down,
  output logic       o_skip,
  output logic       o_dir
);

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [6:0] seg_r;
  logic [6:0] cand;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [6:0] last_pat;
  logic [0:0] state;

  logic       accept;
  logic       accept_new;
  logic       dec_ok;
  logic [3:0] dec_digit;
  logic       is_blank;

  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7D:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h6F:   r = {1'b1, 4'd9};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_r <= '0;
    else       seg_r <= i_seg;
  end

  // Accept fires on the edge where cnt reaches SC; the restart branch counts as one sample.
  always_comb begin
    cnt_next = cnt;
    accept   = 1'b0;
    if (seg_r != cand) begin
      cnt_next = 4'd1;
      accept   = (SC == 4'd1);
    end else if (cnt < SC) begin
      cnt_next = cnt + 4'd1;
      accept   = ((cnt + 4'd1) == SC);
    end
  end

  assign accept_new           = accept && (seg_r != last_pat);
  assign {dec_ok, dec_digit}  = decode(seg_r);
  assign is_blank             = (seg_r == 7'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand     <= '0;
      cnt      <= '0;
      last_pat <= '0;
      state    <= ST_EMPTY;
      o_digit  <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      cand    <= seg_r;
      cnt     <= cnt_next;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (accept_new) begin
        last_pat <= seg_r;
        if (dec_ok) begin
          o_valid <= 1'b1;
          o_digit <= dec_digit;
          state   <= ST_LOCKED;
        end else if (is_blank) begin
          state   <= ST_EMPTY;
        end else begin
          o_err   <= 1'b1;
          state   <= ST_EMPTY;
        end
      end
    end
  end

`ifdef SEG7_CAPTURE_DIRCHECK_EN
  logic [3:0] prev_plus;
  logic [3:0] prev_minus;
  logic       classify;

  assign prev_plus  = (o_digit == 4'd9) ? 4'd0 : o_digit + 4'd1;
  assign prev_minus = (o_digit == 4'd0) ? 4'd9 : o_digit - 4'd1;
  assign classify   = accept_new && dec_ok && (state == ST_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_step_up   <= 1'b0;
      o_step_down <= 1'b0;
      o_skip      <= 1'b0;
      o_dir       <= 1'b1;
    end else begin
      o_step_up   <= 1'b0;
      o_step_down <= 1'b0;
      o_skip      <= 1'b0;
      if (classify) begin
        if (dec_digit == prev_plus) begin
          o_step_up <= 1'b1;
          o_dir     <= 1'b1;
        end else if (dec_digit == prev_minus) begin
          o_step_down <= 1'b1;
          o_dir       <= 1'b0;
        end else begin
          o_skip <= 1'b1;
        end
      end
    end
  end
`else
  // The FSM still tracks EMPTY/LOCKED here; nothing downstream consumes it in this build.
  logic unused_state;
  assign unused_state = state[0];

  assign o_step_up   = 1'b0;
  assign o_step_down = 1'b0;
  assign o_skip      = 1'b0;
  assign o_dir       = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: three instances (STABLE_CYCLES 4, 1, 15) checked every cycle against a run-length model.
module tb_seg7_capture;

  localparam int N = 3;
`ifdef SEG7_CAPTURE_DIRCHECK_EN
  localparam bit DIRCHK = 1'b1;
`else
  localparam bit DIRCHK = 1'b0;
`endif

  function automatic int sc_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] i_seg = '0;

  logic [3:0] d_digit [N];
  logic       d_valid [N];
  logic       d_err   [N];
  logic       d_up    [N];
  logic       d_down  [N];
  logic       d_skip  [N];
  logic       d_dir   [N];

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(4)) u0 (
    .clk(clk), .reset(reset), .i_seg(i_seg), .o_digit(d_digit[0]), .o_valid(d_valid[0]),
    .o_err(d_err[0]), .o_step_up(d_up[0]), .o_step_down(d_down[0]), .o_skip(d_skip[0]), .o_dir(d_dir[0]));
  seg7_capture #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .i_seg(i_seg), .o_digit(d_digit[1]), .o_valid(d_valid[1]),
    .o_err(d_err[1]), .o_step_up(d_up[1]), .o_step_down(d_down[1]), .o_skip(d_skip[1]), .o_dir(d_dir[1]));
  seg7_capture #(.STABLE_CYCLES(15)) u2 (
    .clk(clk), .reset(reset), .i_seg(i_seg), .o_digit(d_digit[2]), .o_valid(d_valid[2]),
    .o_err(d_err[2]), .o_step_up(d_up[2]), .o_step_down(d_down[2]), .o_skip(d_skip[2]), .o_dir(d_dir[2]));

  logic [6:0] dig_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state: sampled input, current run of identical candidates, last accepted pattern.
  logic [6:0] m_seg_r    [N];
  logic [6:0] m_run_val  [N];
  int         m_run_len  [N];
  logic [6:0] m_last_pat [N];
  bit         m_locked   [N];
  logic [3:0] m_digit    [N];
  logic       m_dir      [N];
  logic       e_valid [N];
  logic       e_err   [N];
  logic       e_up    [N];
  logic       e_down  [N];
  logic       e_skip  [N];

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++)
      if (dig_tab[k] == p) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_seg_r[i] = '0; m_run_val[i] = '0; m_run_len[i] = 0; m_last_pat[i] = '0;
      m_locked[i] = 1'b0; m_digit[i] = '0; m_dir[i] = 1'b1;
      e_valid[i] = 1'b0; e_err[i] = 1'b0; e_up[i] = 1'b0; e_down[i] = 1'b0; e_skip[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [6:0] in);
    for (int i = 0; i < N; i++) begin
      logic [6:0] c;
      int d;
      c = m_seg_r[i];
      e_valid[i] = 1'b0; e_err[i] = 1'b0; e_up[i] = 1'b0; e_down[i] = 1'b0; e_skip[i] = 1'b0;
      if (c == m_run_val[i]) m_run_len[i]++;
      else begin
        m_run_val[i] = c;
        m_run_len[i] = 1;
      end
      if (m_run_len[i] == sc_of(i) && c != m_last_pat[i]) begin
        m_last_pat[i] = c;
        d = decode(c);
        if (d >= 0) begin
          e_valid[i] = 1'b1;
          if (m_locked[i] && DIRCHK) begin
            if (d == (int'(m_digit[i]) + 1) % 10) begin
              e_up[i] = 1'b1; m_dir[i] = 1'b1;
            end else if (d == (int'(m_digit[i]) + 9) % 10) begin
              e_down[i] = 1'b1; m_dir[i] = 1'b0;
            end else e_skip[i] = 1'b1;
          end
          m_digit[i] = 4'(d);
          m_locked[i] = 1'b1;
        end else begin
          e_err[i] = (c != 7'h00);
          m_locked[i] = 1'b0;
        end
      end
      m_seg_r[i] = in;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        chk("digit", i, 8'(d_digit[i]), 8'(m_digit[i]));
        chk("valid", i, 8'(d_valid[i]), 8'(e_valid[i]));
        chk("err",   i, 8'(d_err[i]),   8'(e_err[i]));
        chk("up",    i, 8'(d_up[i]),    8'(e_up[i]));
        chk("down",  i, 8'(d_down[i]),  8'(e_down[i]));
        chk("skip",  i, 8'(d_skip[i]),  8'(e_skip[i]));
        chk("dir",   i, 8'(d_dir[i]),   8'(m_dir[i]));
      end
    end
  end

  task automatic step(input logic [6:0] pat, input logic rst);
    @(posedge clk);
    if (reset) model_reset();
    else model_step(i_seg);
    #2;
    i_seg = pat;
    reset = rst;
    if (rst) model_reset();
  endtask

  // Apply pat for 10 cycles; literal checks on the STABLE_CYCLES=4 instance and the model.
  task automatic apply(input logic [6:0] pat, input logic ev, input logic er, input logic [3:0] dg,
                       input logic up, input logic dn, input logic sk, input logic dr);
    step(pat, 1'b0);
    repeat (4) step(pat, 1'b0);
    @(negedge clk);
    chk("early_valid", 0, 8'(d_valid[0]), 8'h0);
    chk("early_err",   0, 8'(d_err[0]),   8'h0);
    step(pat, 1'b0);
    @(negedge clk);
    chk("lit_valid", 0, 8'(d_valid[0]), 8'(ev));
    chk("lit_err",   0, 8'(d_err[0]),   8'(er));
    chk("lit_digit", 0, 8'(d_digit[0]), 8'(dg));
    chk("lit_up",    0, 8'(d_up[0]),    8'(DIRCHK & up));
    chk("lit_down",  0, 8'(d_down[0]),  8'(DIRCHK & dn));
    chk("lit_skip",  0, 8'(d_skip[0]),  8'(DIRCHK & sk));
    chk("lit_dir",   0, 8'(d_dir[0]),   8'(DIRCHK ? dr : 1'b1));
    chk("model_valid", 0, 8'(e_valid[0]), 8'(ev));
    chk("model_digit", 0, 8'(m_digit[0]), 8'(dg));
    repeat (4) step(pat, 1'b0);
  endtask

  initial begin
    bit seen;
    logic [6:0] pat;
    int r;
    model_reset();
    #1 reset = 1'b1;
    checking = 1'b1;
    repeat (3) step(7'h00, 1'b1);
    step(7'h00, 1'b0);
    repeat (20) step(7'h00, 1'b0);
    @(negedge clk);
    chk("blank_valid", 0, 8'(d_valid[0]), 8'h0);
    chk("blank_digit", 0, 8'(d_digit[0]), 8'h0);

    apply(7'h3F, 1, 0, 4'd0, 0, 0, 0, 1);
    apply(7'h06, 1, 0, 4'd1, 1, 0, 0, 1);
    apply(7'h6F, 1, 0, 4'd9, 0, 0, 1, 1);
    apply(7'h3F, 1, 0, 4'd0, 1, 0, 0, 1);
    apply(7'h6F, 1, 0, 4'd9, 0, 1, 0, 0);
    apply(7'h5B, 1, 0, 4'd2, 0, 0, 1, 0);
    apply(7'h07, 1, 0, 4'd7, 0, 0, 1, 0);
    apply(7'h5B, 1, 0, 4'd2, 0, 0, 1, 0);

    seen = 1'b0;
    repeat (3) begin
      step(7'h4F, 1'b0);
      @(negedge clk);
      seen |= d_valid[0] | d_err[0];
    end
    repeat (10) begin
      step(7'h5B, 1'b0);
      @(negedge clk);
      seen |= d_valid[0] | d_err[0];
    end
    chk("glitch_quiet", 0, 8'(seen), 8'h0);

    apply(7'h4F, 1, 0, 4'd3, 1, 0, 0, 1);
    apply(7'h49, 0, 1, 4'd3, 0, 0, 0, 1);
    apply(7'h66, 1, 0, 4'd4, 0, 0, 0, 1);

    // Reset one edge before the accept would have landed.
    repeat (4) step(7'h5B, 1'b0);
    step(7'h5B, 1'b1);
    step(7'h5B, 1'b0);
    @(negedge clk);
    chk("rst_valid", 0, 8'(d_valid[0]), 8'h0);
    chk("rst_digit", 0, 8'(d_digit[0]), 8'h0);
    chk("rst_dir",   0, 8'(d_dir[0]),   8'h1);
    repeat (20) step(7'h5B, 1'b0);

    // Reset while the strobe is high.
    repeat (5) step(7'h6F, 1'b0);
    step(7'h6F, 1'b1);
    @(negedge clk);
    chk("cut_valid", 0, 8'(d_valid[0]), 8'h0);
    chk("cut_digit", 0, 8'(d_digit[0]), 8'h0);
    step(7'h6F, 1'b0);

    repeat (200) begin
      r = $urandom_range(0, 99);
      if (r < 70) pat = dig_tab[$urandom_range(0, 9)];
      else if (r < 82) pat = 7'h00;
      else pat = 7'($urandom);
      repeat ($urandom_range(1, 18)) step(pat, 1'b0);
      if ($urandom_range(0, 59) == 0) begin
        step(pat, 1'b1);
        step(pat, 1'b0);
      end
    end
    repeat (20) step(7'h00, 1'b0);
    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive-side companion to the tick-driven 0–9 counter and its 7-segment encoder. Samples a 7-segment pattern, requires it stable for a programmable number of cycles, and decodes it back to a BCD digit. Classifies each newly accepted digit as a step up, step down or skip relative to the previous one. Sits on `uio_in` of the top level for loopback/self-check of the display path, or for reading another board's display.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted; legal range 1..15.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_seg`  in  7  segment pattern, bit0=a … bit6=g, active-high.
- `o_digit`  out  4  last accepted valid digit 0–9; holds between accepts.
- `o_valid`  out  1  one-cycle strobe: new valid digit accepted.
- `o_err`  out  1  one-cycle strobe: new non-digit, non-blank pattern accepted.
- `o_step_up`  out  1  one-cycle strobe: accepted digit = previous+1 mod 10.
- `o_step_down`  out  1  one-cycle strobe: accepted digit = previous−1 mod 10.
- `o_skip`  out  1  one-cycle strobe: accepted digit is any other value.
- `o_dir`  out  1  1 = last step was up, 0 = down; holds otherwise.

## Operation
- Digit patterns (hex, g..a) are exactly: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- 00 is blank. Every other code is invalid.
- Input stage: `seg_r` registers `i_seg` every cycle. This is the only input flop.
- Stability filter: candidate `cand` (7 b) and counter `cnt` (4 b, saturating at `STABLE_CYCLES`).
  - If `seg_r != cand`: `cand <= seg_r`, `cnt <= 1`.
  - Else if `cnt < STABLE_CYCLES`: `cnt <= cnt + 1`.
- Accept event: the edge on which `cnt` becomes `STABLE_CYCLES`, including the `cnt <= 1` branch when `STABLE_CYCLES` = 1.
- An accept is ignored when `cand` equals `last_pat`, the last accepted pattern. Glitches shorter than `STABLE_CYCLES` that return to the same pattern therefore produce no event.
- FSM has two states: EMPTY (no previous digit) and LOCKED (previous digit held in `o_digit`).
- Accept of a valid digit:
  - `o_valid` pulses and `o_digit` updates.
  - In LOCKED: exactly one of `o_step_up`, `o_step_down` or `o_skip` pulses.
  - In EMPTY: none of those three pulses.
  - Next state is LOCKED.
- Wrap-around: 9→0 is a step up; 0→9 is a step down.
- Accept of blank: no strobes, `o_digit` holds, next state EMPTY.
- Accept of an invalid code: `o_err` pulses, `o_digit` holds, next state EMPTY.
- `last_pat` updates on every non-ignored accept.
- `o_dir` updates only on `o_step_up` (to 1) or `o_step_down` (to 0).
- At most one of `o_valid` / `o_err` is high in any cycle. Step strobes are high only together with `o_valid`.

## Timing
- Reset values:
  - `seg_r`, `cand`, `last_pat` = 00; `cnt` = 0; state EMPTY.
  - `o_digit` = 0, `o_dir` = 1, all strobes = 0.
- A stable blank after reset generates no event.
- Latency: `i_seg` changes before edge E0 and is then held. `seg_r` updates at E0 and `cand` at E1. The strobes and `o_digit` are registered and are high for exactly the cycle following edge E`STABLE_CYCLES`. Default: visible after the 5th edge.
- Any change of `seg_r` before `cnt` reaches `STABLE_CYCLES` restarts the count. No partial accept occurs.
- Reset mid-count or mid-strobe clears everything immediately (asynchronously). A strobe in progress is cut short.
- All outputs are driven from flops. There is no combinational path from `i_seg` to any output.

## Configuration
- `SEG7_CAPTURE_DIRCHECK_EN` defined:
  - Step classification logic is built.
  - `o_step_up`, `o_step_down`, `o_skip` and `o_dir` behave as above.
- Not defined:
  - Classification logic is omitted.
  - `o_step_up`, `o_step_down` and `o_skip` are tied to 0; `o_dir` is tied to 1.
  - Stability filter, decode, `o_valid`, `o_err` and the FSM are unchanged.

## Test plan
- Reset, hold `i_seg`=00 for 20 cycles -> no strobes; `o_digit`=0.
- Apply 3F, then 06, each held 10 cycles, `STABLE_CYCLES`=4 -> first `o_valid` with `o_digit`=0 and no step strobe; second `o_valid` with `o_digit`=1 and `o_step_up`; each strobe 5 edges after its change.
- From LOCKED on 9 (6F) apply 3F -> `o_step_up`, `o_dir`=1. From 0 apply 6F -> `o_step_down`, `o_dir`=0. 2→7 -> `o_skip`.
- Holding 5B (2), inject 4F for 3 cycles, then return to 5B -> no strobe at all.
- Holding 4F, apply 49 for 10 cycles -> `o_err` once. Then apply 66 -> `o_valid`, `o_digit`=4, no step strobe (state was EMPTY).
- Assert `reset` one cycle before an expected accept -> no strobe; `o_digit`=0; outputs at reset values. With the macro undefined, the step sequence above yields `o_step_*`/`o_skip`=0 and `o_dir`=1.
